// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32 funct3 width codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Halfword codes (signed or unsigned) share the low two funct3 bits.
  function automatic logic is_half(input logic [2:0] f3);
    return f3[1:0] == 2'b01;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes/replication, load extract/extend, legality.
// LSU_MISALIGN_CHECK_EN adds halfword/word alignment errors to the legality check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        legal_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};

    case (funct3_i)
      F3_B, F3_H, F3_W: legal_o = 1'b1;
      F3_BU, F3_HU:     legal_o = !store_i;
      default:          legal_o = 1'b0;
    endcase
`ifdef LSU_MISALIGN_CHECK_EN
    if (is_half(funct3_i) && off_i[0])        legal_o = 1'b0;
    if (funct3_i == F3_W && off_i != 2'b00)   legal_o = 1'b0;
`endif

    // Strobes shifted past lane 3 are simply dropped; there is no access split.
    wstrb_o = 4'b0000;
    wdata_o = wdata_i;
    if (store_i) begin
      case (funct3_i)
        F3_B: begin
          wstrb_o = 4'(4'b0001 << off_i);
          wdata_o = {4{wdata_i[7:0]}};
        end
        F3_H: begin
          wstrb_o = 4'(4'b0011 << off_i);
          wdata_o = {2{wdata_i[15:0]}};
        end
        F3_W:    wstrb_o = 4'b1111;
        default: wstrb_o = 4'b0000;
      endcase
    end

    case (funct3_i)
      F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    rdata_o = shifted;
      F3_BU:   rdata_o = {24'd0, shifted[7:0]};
      F3_HU:   rdata_o = {16'd0, shifted[15:0]};
      default: rdata_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time over a valid/ready data bus, registered response.
// Build option LSU_MISALIGN_CHECK_EN (see lsu_align) turns misaligned accesses into errors.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  state_e            state_q;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic              req_ready_q;
  logic              mem_valid_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_wstrb_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              resp_valid_q, resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;

  logic        a_store;
  logic [2:0]  a_funct3;
  logic [1:0]  a_off;
  logic [3:0]  a_wstrb;
  logic [31:0] a_wdata, a_rdata;
  logic        a_legal;

  // One align instance: fed by the incoming request in IDLE, by the latched request otherwise.
  always_comb begin
    a_store  = (state_q == S_IDLE) ? req_store      : store_q;
    a_funct3 = (state_q == S_IDLE) ? req_funct3     : funct3_q;
    a_off    = (state_q == S_IDLE) ? req_addr[1:0]  : off_q;
  end

  lsu_align u_align (
    .store_i  (a_store),
    .funct3_i (a_funct3),
    .off_i    (a_off),
    .wdata_i  (req_wdata),
    .rdata_i  (mem_rdata),
    .wstrb_o  (a_wstrb),
    .wdata_o  (a_wdata),
    .rdata_o  (a_rdata),
    .legal_o  (a_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
      req_ready_q  <= 1'b1;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wstrb_q  <= 4'd0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          store_q     <= req_store;
          funct3_q    <= req_funct3;
          off_q       <= req_addr[1:0];
          req_ready_q <= 1'b0;
          if (a_legal) begin
            state_q     <= S_REQ;
            mem_valid_q <= 1'b1;
            mem_we_q    <= req_store;
            mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_wstrb_q <= a_wstrb;
            mem_wdata_q <= a_wdata;
          end else begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end
        end
        S_REQ: if (mem_ready) begin
          state_q     <= S_WAIT;
          mem_valid_q <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_wstrb_q <= 4'd0;
        end
        S_WAIT: if (mem_rvalid) begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= store_q ? '0 : a_rdata;
        end
        S_RESP: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_valid  = mem_valid_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed + random bench for lsu against an arithmetic reference model of the lane rules.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: legality, strobes, store data, load result.
  function automatic bit m_legal(input bit st, input int f3, input int off);
    bit ok;
    if (st) ok = (f3 == 0 || f3 == 1 || f3 == 2);
    else    ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
`ifdef LSU_MISALIGN_CHECK_EN
    if ((f3 == 1 || f3 == 5) && (off % 2) != 0) ok = 0;
    if (f3 == 2 && off != 0) ok = 0;
`endif
    return ok;
  endfunction

  function automatic logic [3:0] m_strb(input bit st, input int f3, input int off);
    if (!st) return 4'd0;
    if (f3 == 0) return 4'((1 << off) % 16);
    if (f3 == 1) return 4'((3 << off) % 16);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] w);
    if (f3 == 0) return (w & 32'hFF) * 32'h01010101;
    if (f3 == 1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input int f3, input int off, input logic [31:0] r);
    logic [31:0] v;
    v = r >> (8 * off);
    case (f3)
      0: return ((v & 255) >= 128) ? ((v & 255) | 32'hFFFFFF00) : (v & 255);
      1: return ((v & 65535) >= 32768) ? ((v & 65535) | 32'hFFFF0000) : (v & 65535);
      2: return v;
      4: return v & 255;
      5: return v & 65535;
      default: return 32'd0;
    endcase
  endfunction

  // Runs one transaction from IDLE; called with inputs freshly settled 1ns after an edge.
  task automatic txn(input bit st, input int f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input int rdy_wait, input int rv_wait);
    int off;
    off = int'(addr[1:0]);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1; req_store = st; req_funct3 = 3'(f3); req_addr = addr; req_wdata = wd;
    step();
    req_valid = 0;
    req_wdata = $urandom;
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    if (!m_legal(st, f3, off)) begin
      chk("err_valid", 32'(resp_valid), 32'd1);
      chk("err_flag", 32'(resp_err), 32'd1);
      chk("err_rdata", resp_rdata, 32'd0);
      chk("err_no_bus", 32'(mem_valid), 32'd0);
      step();
      chk("err_done", 32'(resp_valid), 32'd0);
      chk("err_ready", 32'(req_ready), 32'd1);
      return;
    end
    for (int i = 0; i <= rdy_wait; i++) begin
      chk("mem_valid", 32'(mem_valid), 32'd1);
      chk("mem_addr", mem_addr, addr & 32'hFFFFFFFC);
      chk("mem_we", 32'(mem_we), 32'(st));
      chk("mem_wstrb", 32'(mem_wstrb), 32'(m_strb(st, f3, off)));
      if (st) chk("mem_wdata", mem_wdata, m_wdata(f3, wd));
      mem_ready = (i == rdy_wait);
      step();
    end
    mem_ready = 0;
    chk("mem_valid_drop", 32'(mem_valid), 32'd0);
    for (int i = 0; i < rv_wait; i++) begin
      chk("wait_no_resp", 32'(resp_valid), 32'd0);
      step();
    end
    mem_rvalid = 1; mem_rdata = rd;
    step();
    mem_rvalid = 0; mem_rdata = $urandom;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_err", 32'(resp_err), 32'd0);
    chk("resp_rdata", resp_rdata, st ? 32'd0 : m_load(f3, off, rd));
    step();
    chk("resp_pulse", 32'(resp_valid), 32'd0);
    chk("back_idle", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1; req_valid = 0; req_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    step(); step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp", {29'd0, resp_valid, resp_err, 1'b0}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    rst = 0;
    step();

    // Minimum latency LW, sign/zero byte loads, stalled SH, illegal codes.
    txn(0, 2, 32'h100, 0, 32'hDEADBEEF, 0, 0);
    txn(0, 0, 32'h103, 0, 32'h80123456, 0, 0);
    txn(0, 4, 32'h103, 0, 32'h80123456, 0, 0);
    txn(1, 1, 32'h102, 32'h1234ABCD, 0, 3, 1);
    chk("sh_strb_model", 32'(m_strb(1, 1, 2)), 32'hC);
    txn(0, 2, 32'h101, 0, 32'hCAFEF00D, 1, 0);
    txn(0, 3, 32'h200, 0, 0, 0, 0);
    txn(1, 4, 32'h200, 32'h55, 0, 0, 0);
    txn(1, 1, 32'h203, 32'hBEEF, 0, 0, 0);

    // Stray mem_rvalid while idle must be ignored.
    mem_rvalid = 1; step(); mem_rvalid = 0;
    chk("stray_rvalid", 32'(resp_valid), 32'd0);
    chk("stray_ready", 32'(req_ready), 32'd1);

    // Reset while waiting for the response, then a late rvalid.
    req_valid = 1; req_store = 0; req_funct3 = 3'd2; req_addr = 32'h300;
    step(); req_valid = 0;
    mem_ready = 1; step(); mem_ready = 0;
    rst = 1; step(); rst = 0;
    chk("mid_rst_idle", 32'(req_ready), 32'd1);
    chk("mid_rst_mem", 32'(mem_valid), 32'd0);
    mem_rvalid = 1; mem_rdata = 32'h12345678; step(); mem_rvalid = 0;
    chk("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    step();
    chk("mid_rst_no_resp2", 32'(resp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);

    for (int n = 0; n < 300; n++) begin
      txn(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom, $urandom,
          $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the EXU in the simple CPU datapath. It accepts one memory request per transaction: the EXU-computed address, store data and RV32 funct3 width code. It drives a valid/ready data-memory bus with byte strobes and returns sign- or zero-extended load data for IDU write-back. The CPU holds the current instruction while the LSU is busy; `req_ready` low is the stall condition.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; fixed at 32, any other value is unsupported
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  LSU can accept a request (high only in IDLE)
- `req_store`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32 width/sign code
- `req_addr`  in  32  byte address from EXU
- `req_wdata`  in  32  rs2 value for stores
- `mem_valid`  out  1  bus request valid
- `mem_ready`  in  1  bus accepts request
- `mem_we`  out  1  write enable
- `mem_addr`  out  32  word address, bits [1:0] forced 0
- `mem_wstrb`  out  4  byte-lane write strobes
- `mem_wdata`  out  32  lane-replicated store data
- `mem_rvalid`  in  1  bus response (load data or store ack)
- `mem_rdata`  in  32  raw word read
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  extended load data; 0 for stores and errors
- `resp_err`  out  1  illegal funct3 or misaligned access

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: `req_ready`=1. When `req_valid` is high, latch addr, funct3, store and wdata.
  - Access legal: go to REQ.
  - Access illegal: go to RESP with error. No bus activity.
- REQ: `mem_valid`=1. All `mem_*` request outputs are held stable until `mem_ready`=1, then go to WAIT.
- WAIT: wait for `mem_rvalid`.
  - Loads: register extracted data.
  - Stores: treat `mem_rvalid` as the ack.
  - Then go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. No backpressure on the response.
- Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store funct3: 000 SB, 001 SH, 010 SW. Any other code is illegal.
- Store lanes, with off = `addr[1:0]`:
  - SB: `wstrb` = 0001<<off, `wdata` = byte replicated ×4.
  - SH: `wstrb` = 0011<<off, `wdata` = half replicated ×2.
  - SW: `wstrb` = 1111.
- Loads: `mem_rdata` >> (8×off), then truncate to the access size. LB/LH sign-extend; LBU/LHU zero-extend.
- `mem_we` = latched store bit; `mem_wstrb` = 0000 for loads.
- `mem_rvalid` is ignored outside WAIT.

## Timing
- Reset: state IDLE. All outputs 0 except `req_ready`=1. Latched registers are cleared.
- `rst` mid-transaction: at the next edge the FSM is in IDLE and `mem_valid` drops. A late `mem_rvalid` is ignored.
- Minimum legal latency:
  - Cycle 0: accept.
  - Cycle 1: `mem_valid` with `mem_ready`.
  - Cycle 2: `mem_rvalid`.
  - Cycle 3: `resp_valid`.
- Error latency: accept at cycle 0, `resp_valid`+`resp_err` at cycle 1.
- `mem_rvalid` arrives no earlier than the cycle after the request handshake. Same-cycle responses are not supported.
- `resp_rdata`/`resp_err` are registered and valid only while `resp_valid` is high.
- `req_valid` during REQ/WAIT/RESP is not accepted; `req_ready`=0.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: these accesses are errors with no bus access:
  - LH/LHU/SH with `addr[0]`=1.
  - LW/SW with `addr[1:0]`≠0.
- Undefined: no misalignment check. Lanes are computed from off as above; bits shifted past lane 3 are dropped (no access split).

## Structure
- Package `lsu_pkg`: FSM state enum, funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
- Sub-module `lsu_align`: purely combinational. Computes strobe generation, store-data replication, load extraction/extension and the legality check. The FSM lives in `lsu`.

## Test plan
- LW at 0x100, `mem_ready` at cycle 1, `mem_rvalid` at cycle 2 with 0xDEADBEEF -> `resp_valid` at cycle 3, `resp_rdata`=0xDEADBEEF, `resp_err`=0.
- LB at 0x103, `mem_rdata`=0x80xxxxxx -> `resp_rdata`=0xFFFFFF80; LBU same -> 0x00000080.
- SH at 0x102, `wdata`=0x1234ABCD -> `mem_addr`=0x100, `mem_wstrb`=1100, `mem_wdata`=0xABCDABCD, `mem_we`=1; hold `mem_ready`=0 for 3 cycles -> outputs stable.
- LW at 0x101 with macro defined -> `resp_err`=1 at cycle 1, `mem_valid` never asserted. funct3=011 -> same error in both configurations.
- `rst` asserted in WAIT, then `mem_rvalid` pulses -> IDLE, `req_ready`=1, no `resp_valid`.
